// File: rtl/alu3_pkg.sv
// rtl/alu3_pkg.sv - shared types and constants for the 3-bit accumulate controller
//
// Contents:
//   ALU3_WIDTH    default accumulator/operand width
//   alu3_op_e     command opcodes (NOP, LOAD, ADD, CLEAR)
//   alu3_state_e  sequencer states (IDLE, EXEC, HOLD)
package alu3_pkg;

  localparam int ALU3_WIDTH = 3;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_ADD   = 2'b10,
    OP_CLEAR = 2'b11
  } alu3_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } alu3_state_e;

endpackage

// File: rtl/alu3_rr_arb.sv
// rtl/alu3_rr_arb.sv - 2-way round-robin arbiter (combinational, pointer kept by parent)
//
// Ports:
//   valid  in  2  request valids, bit i = requester i
//   ptr    in  1  requester favoured when both are valid
//   grant  out 2  one-hot grant, zero when no valid
module alu3_rr_arb
  import alu3_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu3_seq_ctrl.sv
// rtl/alu3_seq_ctrl.sv - two-requester sequencer/arbiter for the 3-bit accumulator
//
// Build option: define ALU3_SAT_EN to make ADD saturate at 2^WIDTH-1 instead of wrapping.
//
// Ports:
//   Clock, Resetn                 clock (rising edge), asynchronous active-low reset
//   req0_valid/op/data/ready      requester 0 command handshake
//   req1_valid/op/data/ready      requester 1 command handshake
//   acc_q      out WIDTH          accumulator
//   carry_q    out 1              sticky carry/overflow
//   hex_nibble out 4              {carry_q, acc_q} for the 7-segment decoder
//   done       out 1              one-cycle pulse after the accumulator is updated
//   grant_id   out 1              requester of the last accepted command
//   busy       out 1              sequencer not idle
module alu3_seq_ctrl
  import alu3_pkg::*;
#(
  parameter int WIDTH       = ALU3_WIDTH,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] acc_q,
  output logic             carry_q,
  output logic [3:0]       hex_nibble,
  output logic             done,
  output logic             grant_id,
  output logic             busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  alu3_state_e      state, state_nxt;
  logic             ptr;
  logic [1:0]       grant;
  logic             accept;
  alu3_op_e         op_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    hold_cnt;
  logic             hold_last;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   nib_full;

  alu3_rr_arb u_arb (
    .valid (  {req1_valid, req0_valid}),
    .ptr   (  ptr),
    .grant (  grant)
  );

  // Arbitration runs continuously, but a grant only counts while idle.
  assign accept    = (state == ST_IDLE) && (grant != 2'b00);
  assign hold_last = ({{(32-CW){1'b0}}, hold_cnt} == 32'(HOLD_CYCLES - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (accept) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (hold_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hold_cnt <= '0;
    end else if (state == ST_EXEC) begin
      hold_cnt <= '0;
    end else if (state == ST_HOLD) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Command capture; the pointer then favours whoever was not just served.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      op_q     <= OP_NOP;
      data_q   <= '0;
      grant_id <= 1'b0;
      ptr      <= 1'b0;
    end else if (accept) begin
      op_q     <= grant[1] ? alu3_op_e'(req1_op) : alu3_op_e'(req0_op);
      data_q   <= grant[1] ? req1_data : req0_data;
      grant_id <= grant[1];
      ptr      <= ~grant[1];
    end
  end

  assign sum = {1'b0, acc_q} + {1'b0, data_q};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == ST_EXEC);
      if (state == ST_EXEC) begin
        case (op_q)
          OP_LOAD: begin
            acc_q   <= data_q;
            carry_q <= 1'b0;
          end
          OP_ADD: begin
`ifdef ALU3_SAT_EN
            acc_q   <= sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
            acc_q   <= sum[WIDTH-1:0];
`endif
            carry_q <= carry_q | sum[WIDTH];
          end
          OP_CLEAR: begin
            acc_q   <= '0;
            carry_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign nib_full   = {carry_q, acc_q};
  assign hex_nibble = 4'(nib_full);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu3_seq_ctrl.sv
// tb/tb_alu3_seq_ctrl.sv - self-checking bench for alu3_seq_ctrl
module tb_alu3_seq_ctrl;
  import alu3_pkg::*;

  localparam int W    = 3;
  localparam int HOLD = 2;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  logic         v0 = 0, v1 = 0, rdy0, rdy1;
  logic [1:0]   op0 = 0, op1 = 0;
  logic [W-1:0] d0 = 0, d1 = 0;
  logic [W-1:0] acc;
  logic         carry, done, gid, busy;
  logic [3:0]   hex;

  logic         zv0 = 0, zv1 = 0, zrdy0, zrdy1;
  logic [1:0]   zop0 = 0, zop1 = 0;
  logic [W-1:0] zd0 = 0, zd1 = 0;
  logic [W-1:0] zacc;
  logic         zcarry, zdone, zgid, zbusy;
  logic [3:0]   zhex;

  alu3_seq_ctrl #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req0_valid(v0), .req0_op(op0), .req0_data(d0), .req0_ready(rdy0),
    .req1_valid(v1), .req1_op(op1), .req1_data(d1), .req1_ready(rdy1),
    .acc_q(acc), .carry_q(carry), .hex_nibble(hex), .done(done),
    .grant_id(gid), .busy(busy)
  );

  alu3_seq_ctrl #(.WIDTH(W), .HOLD_CYCLES(0)) dut_h0 (
    .Clock(Clock), .Resetn(Resetn),
    .req0_valid(zv0), .req0_op(zop0), .req0_data(zd0), .req0_ready(zrdy0),
    .req1_valid(zv1), .req1_op(zop1), .req1_data(zd1), .req1_ready(zrdy1),
    .acc_q(zacc), .carry_q(zcarry), .hex_nibble(zhex), .done(zdone),
    .grant_id(zgid), .busy(zbusy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int acc;
    int carry;
    int gid;
    int cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int r;
    int op;
    int d;
    int eacc;
    int ecar;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding accept.
  always @(negedge Clock) begin : mon
    exp_t e;
    if (Resetn && done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_acc", int'(acc), e.acc);
        check("sb_carry", int'(carry), e.carry);
        check("sb_grant_id", int'(gid), e.gid);
        check("sb_hex", int'(hex), e.carry * 8 + e.acc);
        check("sb_done_latency", cyc - e.cyc, 1);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input int r, input int op, input int d, input int eacc,
                      input int ecar, output int acyc);
    int n;
    acyc = -1;
    if (r == 0) begin v0 = 1; op0 = 2'(op); d0 = 3'(d); end
    else        begin v1 = 1; op1 = 2'(op); d1 = 3'(d); end
    for (n = 0; n < 40; n++) begin
      #1;
      if ((r == 0 && rdy0) || (r == 1 && rdy1)) break;
      @(negedge Clock);
    end
    if (n == 40) begin
      check("ready_timeout", 0, 1);
      v0 = 0; v1 = 0;
      return;
    end
    check("ready_exclusive", int'(rdy0 & rdy1), 0);
    acyc = cyc + 1;
    sb.push_back('{eacc, ecar, r, acyc});
    @(posedge Clock);
    #1;
    check("busy_after_accept", int'(busy), 1);
    v0 = 0; v1 = 0;
    op0 = 2'($urandom); op1 = 2'($urandom);
    d0 = 3'($urandom);  d1 = 3'($urandom);
    @(negedge Clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_acc"}, int'(acc), 0);
    check({tag, "_carry"}, int'(carry), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_grant_id"}, int'(gid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_readys"}, int'({rdy1, rdy0}), 0);
  endtask

  initial begin
    int acyc, prev, k, n;
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};

`ifdef ALU3_SAT_EN
    tbl[3] = '{1, 2, 3, 7, 1};
    tbl[4] = '{0, 2, 1, 7, 1};
    tbl[5] = '{0, 0, 4, 7, 1};
    tbl[8] = '{0, 2, 7, 7, 1};
`else
    tbl[3] = '{1, 2, 3, 1, 1};
    tbl[4] = '{0, 2, 1, 2, 1};
    tbl[5] = '{0, 0, 4, 2, 1};
    tbl[8] = '{0, 2, 7, 6, 1};
`endif
    tbl[0] = '{0, 1, 5, 5, 0};
    tbl[1] = '{0, 2, 1, 6, 0};
    tbl[2] = '{1, 1, 6, 6, 0};
    tbl[6] = '{1, 3, 5, 0, 0};
    tbl[7] = '{1, 2, 7, 7, 0};
    tbl[9] = '{1, 1, 2, 2, 0};

    repeat (2) @(negedge Clock);
    #1;
    check_reset_state("in_reset");
    @(negedge Clock);
    Resetn = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      #1;
      check_reset_state("idle");
    end
    @(negedge Clock);

    prev = -1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].r, tbl[i].op, tbl[i].d, tbl[i].eacc, tbl[i].ecar, acyc);
      if (prev >= 0 && acyc >= 0) check("accept_spacing", acyc - prev, 2 + HOLD);
      prev = acyc;
    end
    repeat (HOLD + 3) @(negedge Clock);
    check("table_drained", sb.size(), 0);
    check("table_final_acc", int'(acc), 2);

    // Reset while the ADD is in EXEC: command lost, no done.
    send(0, 2, 1, 3, 0, acyc);
    #2;
    Resetn = 0;
    sb.delete();
    #1;
    check_reset_state("rst_exec");
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1;
    repeat (4) @(negedge Clock);
    check("rst_exec_acc_after", int'(acc), 0);

    // Reset while in HOLD after an ADD.
    send(1, 2, 5, 5, 0, acyc);
    repeat (2) @(negedge Clock);
    #2;
    check("pre_rst_hold_busy", int'(busy), 1);
    Resetn = 0;
    sb.delete();
    #1;
    check_reset_state("rst_hold");
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1;
    @(negedge Clock);

    // Contention from a fresh reset: grants alternate starting with req0.
    v0 = 1; op0 = 2'(OP_ADD); d0 = 3'd1;
    v1 = 1; op1 = 2'(OP_ADD); d1 = 3'd1;
    k = 0;
    for (n = 0; n < 80 && k < 4; n++) begin
      #1;
      if (rdy0 || rdy1) begin
        check("rr_exclusive", int'(rdy0 & rdy1), 0);
        check("rr_grant", int'(rdy1), exp_g[k]);
        sb.push_back('{k + 1, 0, exp_g[k], cyc + 1});
        k++;
        if (k == 4) begin
          @(posedge Clock);
          #1;
          v0 = 0; v1 = 0;
        end
      end
      @(negedge Clock);
    end
    check("rr_accepts", k, 4);
    repeat (HOLD + 3) @(negedge Clock);
    check("rr_drained", sb.size(), 0);
    check("rr_final_acc", int'(acc), 4);

    // HOLD_CYCLES=0 instance: req1 streaming ADD 1 accepts/dones every 2 cycles.
    zv1 = 1; zop1 = 2'(OP_ADD); zd1 = 3'd1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("h0_ready1", int'(zrdy1), (i % 2 == 0) ? 1 : 0);
      check("h0_ready0", int'(zrdy0), 0);
      check("h0_done", int'(zdone), (i % 2 == 0 && i > 0) ? 1 : 0);
      check("h0_acc", int'(zacc), i / 2);
      @(negedge Clock);
    end
    zv1 = 0;
    repeat (3) @(negedge Clock);
    check("h0_final_acc", int'(zacc), 4);
    check("h0_grant_id", int'(zgid), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
